// File: rtl/eeprom_stream_reader.sv
// 25xx SPI EEPROM READ sequencer streaming BYTE_COUNT bytes over valid/ready; define EEPROM_FAST_READ_EN for FAST READ (0x0B + dummy byte).
// First byte 2+2*(header+8) clk after start at SCLK_DIV=1; backpressure parks sclk low at a byte boundary until the held byte is taken.
module eeprom_stream_reader #(
  parameter int                    BYTE_COUNT = 100,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
  parameter int                    SCLK_DIV   = 1
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  input  logic       abort,
  input  logic       miso,
  output logic       cs_n,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       busy,
  output logic       done
);

`ifdef EEPROM_FAST_READ_EN
  localparam int                  HDR_BITS = 16 + ADDR_WIDTH;
  localparam logic [HDR_BITS-1:0] HDR_WORD = {8'h0B, START_ADDR, 8'h00};
`else
  localparam int                  HDR_BITS = 8 + ADDR_WIDTH;
  localparam logic [HDR_BITS-1:0] HDR_WORD = {8'h03, START_ADDR};
`endif

  localparam int               DIV_W     = $clog2(SCLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(SCLK_DIV - 1);
  localparam int               HCNT_W    = $clog2(HDR_BITS + 1);
  localparam logic [7:0]       LAST_IDX  = 8'(BYTE_COUNT - 1);
  localparam logic [7:0]       ALL_BYTES = 8'(BYTE_COUNT);

  typedef enum logic [2:0] {IDLE, SETUP, HEADER, DATA, STALL, FINISH} state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [HDR_BITS-1:0] hdr_sr;
  logic [HCNT_W-1:0]   hdr_cnt;
  logic [7:0]          rx_sr;
  logic [3:0]          rx_cnt;
  logic [7:0]          byte_cnt;
  logic                take;

  assign take = byte_valid && byte_ready;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      cs_n       <= 1'b1;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      byte_data  <= 8'd0;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_cnt    <= '0;
      hdr_sr     <= '0;
      hdr_cnt    <= '0;
      rx_sr      <= 8'd0;
      rx_cnt     <= 4'd0;
      byte_cnt   <= 8'd0;
    end else begin
      done <= 1'b0;
      if (take) byte_valid <= 1'b0;

      if (abort && state != IDLE) begin
        state      <= IDLE;
        cs_n       <= 1'b1;
        sclk       <= 1'b0;
        mosi       <= 1'b0;
        byte_valid <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state    <= SETUP;
              cs_n     <= 1'b0;
              busy     <= 1'b1;
              mosi     <= HDR_WORD[HDR_BITS-1];
              hdr_sr   <= HDR_WORD;
              hdr_cnt  <= '0;
              div_cnt  <= DIV_MAX;
              rx_cnt   <= 4'd0;
              byte_cnt <= 8'd0;
            end
          end

          SETUP: begin
            if (div_cnt != '0) begin
              div_cnt <= div_cnt - DIV_W'(1);
            end else begin
              div_cnt <= DIV_MAX;
              state   <= HEADER;
            end
          end

          // Each bit is a low phase then a high phase; mosi moves on the fall.
          HEADER: begin
            if (div_cnt != '0) begin
              div_cnt <= div_cnt - DIV_W'(1);
            end else begin
              div_cnt <= DIV_MAX;
              sclk    <= ~sclk;
              if (sclk) begin
                if (hdr_cnt == HCNT_W'(HDR_BITS - 1)) begin
                  state <= DATA;
                  mosi  <= 1'b0;
                end else begin
                  hdr_cnt <= hdr_cnt + HCNT_W'(1);
                  hdr_sr  <= hdr_sr << 1;
                  mosi    <= hdr_sr[HDR_BITS-2];
                end
              end
            end
          end

          DATA: begin
            if (div_cnt != '0) begin
              div_cnt <= div_cnt - DIV_W'(1);
            end else begin
              div_cnt <= DIV_MAX;
              if (!sclk) begin
                sclk   <= 1'b1;
                rx_sr  <= {rx_sr[6:0], miso};
                rx_cnt <= rx_cnt + 4'd1;
              end else begin
                sclk <= 1'b0;
                if (rx_cnt == 4'd8) begin
                  rx_cnt   <= 4'd0;
                  byte_cnt <= byte_cnt + 8'd1;
                  if (!byte_valid || take) begin
                    byte_data  <= rx_sr;
                    byte_valid <= 1'b1;
                    if (byte_cnt == LAST_IDX) begin
                      cs_n  <= 1'b1;
                      state <= FINISH;
                    end
                  end else begin
                    state <= STALL;
                  end
                end
              end
            end
          end

          // rx_sr holds the pending byte while sclk is parked low.
          STALL: begin
            if (take) begin
              byte_data  <= rx_sr;
              byte_valid <= 1'b1;
              div_cnt    <= DIV_MAX;
              if (byte_cnt == ALL_BYTES) begin
                cs_n  <= 1'b1;
                state <= FINISH;
              end else begin
                state <= DATA;
              end
            end
          end

          FINISH: begin
            if (take) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eeprom_stream_reader.sv
// Bench for eeprom_stream_reader: behavioural 25xx EEPROM model plus byte scoreboard, randomized data and backpressure.
module tb_eeprom_stream_reader;
  localparam int BC = 4;
  localparam int AW = 16;
`ifdef EEPROM_FAST_READ_EN
  localparam int          HDR     = 16 + AW;
  localparam logic [63:0] EXP_HDR = 64'h0B00_0000;
`else
  localparam int          HDR     = 8 + AW;
  localparam logic [63:0] EXP_HDR = 64'h03_0000;
`endif
  localparam int LAT    = 2 + 2 * (HDR + 8);
  localparam int BUDGET = 2000;

  logic       clk = 1'b0;
  logic       nreset, start, abort, miso, byte_ready;
  logic       cs_n, sclk, mosi, byte_valid, busy, done;
  logic [7:0] byte_data;

  always #5 clk = ~clk;

  eeprom_stream_reader #(
    .BYTE_COUNT(BC), .ADDR_WIDTH(AW), .START_ADDR(16'h0000), .SCLK_DIV(1)
  ) dut (
    .clk(clk), .nreset(nreset), .start(start), .abort(abort), .miso(miso),
    .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .busy(busy), .done(done)
  );

  logic [7:0]  mem [BC];
  logic [7:0]  rx_q [$];
  int          rises, done_cnt, done_cs_bad, hold_err, sclk_err, mosi_err, txn_cnt;
  logic [63:0] hdr;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // EEPROM model and bus observer, sampled on the falling clk edge.
  initial begin
    logic p_sclk, p_cs, p_vld, p_rdy, p_abort;
    logic [7:0] p_dat;
    int k;
    miso = 1'b0; rises = 0; hdr = '0; done_cnt = 0; done_cs_bad = 0;
    hold_err = 0; sclk_err = 0; mosi_err = 0; txn_cnt = 0;
    p_sclk = 1'b0; p_cs = 1'b1; p_vld = 1'b0; p_rdy = 1'b0; p_abort = 1'b0; p_dat = 8'd0;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        rises = 0; hdr = '0; miso = 1'b0; p_sclk = 1'b0; p_cs = 1'b1; p_vld = 1'b0;
      end else begin
        if (p_cs && !cs_n) begin txn_cnt++; rises = 0; hdr = '0; miso = 1'b0; end
        if (sclk && cs_n) sclk_err++;
        if (!p_sclk && sclk) begin
          if (rises < HDR) hdr = {hdr[62:0], mosi};
          else if (mosi) mosi_err++;
          rises++;
        end
        if (p_sclk && !sclk && !cs_n && rises >= HDR) begin
          k = rises - HDR;
          miso = mem[(k / 8) % BC][7 - (k % 8)];
        end
        if (p_vld && !p_rdy && !p_abort && (!byte_valid || byte_data !== p_dat)) hold_err++;
        if (byte_valid && byte_ready) rx_q.push_back(byte_data);
        if (done) begin done_cnt++; if (!cs_n) done_cs_bad++; end
        p_sclk = sclk; p_cs = cs_n; p_vld = byte_valid; p_rdy = byte_ready;
        p_abort = abort; p_dat = byte_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
  endtask

  task automatic wait_rises(input int target, input string tag);
    int n = 0;
    while (rises < target && n < BUDGET) begin tick(); n++; end
    chk({tag, "_wait"}, 64'(n >= BUDGET), 64'd0);
  endtask

  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < BC; i++) mem[i] = rnd ? 8'($urandom) : 8'h00;
    if (!rnd) begin mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hFF; mem[3] = 8'h00; end
  endtask

  // Runs the rest of a transaction to done and scores it against the model.
  task automatic finish_txn(input string tag, input bit rnd, input int q0, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < BUDGET) begin
      if (rnd) byte_ready = ($urandom_range(0, 3) != 0);
      tick(); n++;
    end
    byte_ready = 1'b1;
    chk({tag, "_timeout"}, 64'(n >= BUDGET), 64'd0);
    repeat (4) tick();
    chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_nbytes"}, 64'(rx_q.size() - q0), 64'(BC));
    for (int i = 0; i < BC; i++)
      if (q0 + i < rx_q.size()) chk({tag, "_byte"}, 64'(rx_q[q0 + i]), 64'(mem[i]));
    chk({tag, "_header"}, hdr, EXP_HDR);
    chk({tag, "_rises"}, 64'(rises), 64'(HDR + 8 * BC));
    chk({tag, "_idle"}, {busy, cs_n, sclk, byte_valid}, 64'b0100);
  endtask

  initial begin
    int q0, d0, t0, r0, lat;
    nreset = 1'b1; start = 1'b0; abort = 1'b0; byte_ready = 1'b0;
    #3 nreset = 1'b0;
    tick(); tick();
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_byte_data", byte_data, 0);
    chk("rst_byte_valid", byte_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    nreset = 1'b1;
    tick();

    // Basic read with first-byte latency
    fill_mem(0);
    byte_ready = 1'b1;
    q0 = rx_q.size(); d0 = done_cnt;
    pulse_start();
    lat = 1;
    while (!byte_valid && lat < 400) begin @(posedge clk); #1; lat++; end
    chk("latency", 64'(lat), 64'(LAT));
    finish_txn("basic", 0, q0, d0);

    // Backpressure: consumer stalls 40 cycles after the first byte appears
    byte_ready = 1'b0;
    q0 = rx_q.size(); d0 = done_cnt;
    pulse_start();
    t0 = 0;
    while (!byte_valid && t0 < 400) begin tick(); t0++; end
    r0 = rises;
    repeat (40) tick();
    chk("bp_hold_data", byte_data, 8'hA5);
    chk("bp_hold_valid", byte_valid, 1);
    chk("bp_sclk_low", sclk, 0);
    chk("bp_cs_low", cs_n, 0);
    chk("bp_rises_during_stall", 64'(rises - r0), 64'd8);
    byte_ready = 1'b1;
    finish_txn("bp", 0, q0, d0);

    // Randomized data and random backpressure
    for (int t = 0; t < 4; t++) begin
      fill_mem(1);
      q0 = rx_q.size(); d0 = done_cnt;
      pulse_start();
      finish_txn("rand", 1, q0, d0);
    end

    // Abort during the 5th bit of data byte 2, first byte left unconsumed
    fill_mem(1);
    byte_ready = 1'b0;
    q0 = rx_q.size(); d0 = done_cnt;
    pulse_start();
    wait_rises(HDR + 12, "abort");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_state", {cs_n, byte_valid, busy, sclk}, 64'b1000);
    repeat (10) tick();
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    byte_ready = 1'b1;
    fill_mem(0);
    q0 = rx_q.size(); d0 = done_cnt;
    pulse_start();
    finish_txn("post_abort", 0, q0, d0);

    // start and abort together in IDLE
    t0 = txn_cnt;
    tick(); start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    chk("start_abort_idle", {busy, cs_n}, 64'b01);
    chk("start_abort_no_txn", 64'(txn_cnt - t0), 64'd0);

    // start again while the header is shifting
    fill_mem(1);
    t0 = txn_cnt; q0 = rx_q.size(); d0 = done_cnt;
    pulse_start();
    wait_rises(5, "busy_start");
    start = 1'b1; tick(); start = 1'b0;
    finish_txn("busy_start", 0, q0, d0);
    chk("busy_start_one_txn", 64'(txn_cnt - t0), 64'd1);

    // Reset during data byte 3, then a clean transaction
    fill_mem(1);
    pulse_start();
    wait_rises(HDR + 19, "mid_reset");
    nreset = 1'b0;
    #1;
    chk("mid_reset_outputs", {cs_n, sclk, byte_valid, busy, done}, 64'b10000);
    tick(); tick();
    nreset = 1'b1;
    tick();
    fill_mem(1);
    q0 = rx_q.size(); d0 = done_cnt;
    pulse_start();
    finish_txn("after_reset", 1, q0, d0);

    chk("sclk_high_with_cs_high", 64'(sclk_err), 64'd0);
    chk("mosi_high_in_data", 64'(mosi_err), 64'd0);
    chk("handshake_hold", 64'(hold_err), 64'd0);
    chk("done_with_cs_low", 64'(done_cs_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/eeprom_stream_reader.md
Name: eeprom_stream_reader

Overview:
- Upstream feeder for the 100-byte pattern shift register.
- On a start pulse, issues an SPI READ (0x03 plus address) to a 25xx-series serial EEPROM.
- Streams BYTE_COUNT data bytes out over a valid/ready byte interface.
- Stalls SCLK at byte boundaries under backpressure.
- Replaces ad-hoc read sequencing in the top-level state machine with a self-contained controller.

Parameters:
- BYTE_COUNT, 100: data bytes read per transaction (1..255).
- ADDR_WIDTH, 16: EEPROM address bits sent after the command (multiple of 8).
- START_ADDR, 0: address transmitted in the header.
- SCLK_DIV, 1: SCLK half-period in clk cycles (>=1).

Ports:
- clk  input  1  system clock
- nreset  input  1  asynchronous active-low reset
- start  input  1  begin transaction; sampled only in IDLE
- abort  input  1  terminate transaction immediately
- miso  input  1  EEPROM serial data out
- cs_n  output  1  EEPROM chip select, active low
- sclk  output  1  SPI clock, mode 0
- mosi  output  1  SPI data to EEPROM, MSB first
- byte_data  output  8  received byte
- byte_valid  output  1  byte_data holds an unconsumed byte
- byte_ready  input  1  consumer accepts byte when high with byte_valid
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse after last byte is accepted

Behaviour:
- Interface (already decided): one clock `clk`; reset `nreset`, asynchronous, active-low.
- Reset values: cs_n=1, sclk=0, mosi=0, byte_data=0, byte_valid=0, busy=0, done=0; state IDLE; counters 0.
- States: IDLE, SETUP, HEADER, DATA, STALL, FINISH.
- IDLE -> SETUP:
  - On start=1, cs_n goes low the next cycle.
  - SETUP lasts SCLK_DIV cycles with sclk=0 and mosi = header bit 7 (CS setup).
- SPI timing, mode 0:
  - sclk holds each level for SCLK_DIV cycles.
  - mosi changes only on the clk edge where sclk falls, or on entry.
  - miso is sampled on the clk edge where sclk rises.
  - One bit = 2*SCLK_DIV clk cycles.
- HEADER:
  - Shifts 8+ADDR_WIDTH bits: 0x03 then START_ADDR, MSB first.
  - After the last falling sclk, go to DATA; mosi=0 from then on.
- DATA:
  - 8-bit receive shift register plus 8-bit byte counter.
  - After the 8th rising edge of a byte, the completed byte transfers to byte_data and byte_valid is set, provided the output register is empty or being consumed that cycle.
  - Otherwise go to STALL.
- STALL:
  - sclk held 0, cs_n held 0.
  - Leave when byte_valid&&byte_ready: load the pending byte, keep byte_valid=1, return to DATA.
- Output handshake:
  - byte_valid stays high and byte_data stays stable until byte_valid&&byte_ready.
  - Simultaneous accept and new-byte load: byte_valid remains 1 with the new data.
- Byte count:
  - After BYTE_COUNT bytes are assembled, sclk stays 0 and cs_n goes high on the next falling-phase boundary.
  - State is FINISH.
- FINISH:
  - Waits for the final byte to be accepted.
  - Then asserts done for one cycle, busy=0, state IDLE.
- Ignored inputs:
  - start while busy=1 has no effect.
  - start and abort together in IDLE: abort wins, no transaction.
- abort in any non-IDLE state, effective the next cycle:
  - cs_n=1, sclk=0, byte_valid=0, state IDLE.
  - No done pulse.
  - Partially assembled byte is discarded.
- Reset mid-transaction: all outputs return to reset values asynchronously. No partial state survives.
- Latency, SCLK_DIV=1, byte_ready tied high:
  - start to first byte_valid = 1 + 1 + 2*(8+ADDR_WIDTH+8) cycles.
  - 66 cycles at ADDR_WIDTH=16.

Optional Feature:
- Macro: EEPROM_FAST_READ_EN.
- Defined: header uses command 0x0B, then address, then one dummy byte 0x00, so the header is 16+ADDR_WIDTH bits. Data phase is unchanged.
- Undefined: command 0x03 with no dummy byte, as described above.

Test Plan:
- Reset check:
  - Stimulus: assert nreset low mid-DATA (byte 3).
  - Response: cs_n=1, sclk=0, byte_valid=0, busy=0 immediately. A following start runs a complete new transaction from the header.
- Basic read:
  - Stimulus: BYTE_COUNT=4, SCLK_DIV=1, byte_ready=1, EEPROM model returns A5,3C,FF,00.
  - Response: mosi header = 0x03,0x00,0x00; 56 rising sclk edges total; bytes A5,3C,FF,00 in order; done pulses once; cs_n high before done.
- Backpressure:
  - Stimulus: byte_ready=0 for 40 cycles after the first byte_valid.
  - Response: byte_data holds A5; sclk freezes low after byte 2 is assembled with cs_n low; streaming resumes on byte_ready; no byte is lost or duplicated.
- Abort:
  - Stimulus: pulse abort during the 5th bit of data byte 2.
  - Response: next cycle cs_n=1, byte_valid=0, busy=0; no done pulse.
- Start while busy:
  - Stimulus: pulse start during HEADER.
  - Response: the transaction proceeds unchanged and only one header is sent.
- Fast read (EEPROM_FAST_READ_EN defined):
  - Stimulus: same transaction as the basic read.
  - Response: header 0x0B,0x00,0x00,0x00; first byte_valid at cycle 82 after start; same data.
